idx_seq: RTL and testbench

Sequencer for the MU0 index-register extension. Accepts one indexed-class instruction at a time from the main MU0 control unit and drives the index-register enable, ALU function and operand selects, effective-address mux and memory request over one or more cycles, then returns a done pulse. Sits beside the main controller; the datapath (index register, ALU, address mux) stays outside this block.

---
 rtl/idx_pkg.sv | 36 +++
 rtl/idx_seq.sv | 180 ++++++++++++++++++
 tb/tb_idx_seq.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/idx_pkg.sv
// Shared definitions for the MU0 index-register extension sequencer:
// opcode values, ALU function codes and the sequencer state encoding.
package idx_pkg;

  // Indexed-class opcodes; anything with bit 3 clear is illegal.
  localparam logic [3:0] OP_LDX  = 4'h8;
  localparam logic [3:0] OP_STX  = 4'h9;
  localparam logic [3:0] OP_ADX  = 4'hA;
  localparam logic [3:0] OP_INX  = 4'hB;
  localparam logic [3:0] OP_DEX  = 4'hC;
  localparam logic [3:0] OP_LDAX = 4'hD;
  localparam logic [3:0] OP_STAX = 4'hE;
  localparam logic [3:0] OP_JXZ  = 4'hF;

  // External ALU function select.
  localparam logic [1:0] FS_PASS_B = 2'd0;
  localparam logic [1:0] FS_ADD    = 2'd1;
  localparam logic [1:0] FS_INC    = 2'd2;
  localparam logic [1:0] FS_DEC    = 2'd3;

  // S_INC is only ever entered when IDX_AUTOINC_EN is defined.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_MEM  = 3'd2,
    S_WB   = 3'd3,
    S_INC  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Legal opcodes are exactly the upper half of the opcode space.
  function automatic logic op_legal(input logic [3:0] op);
    return op[3];
  endfunction

endpackage

// File: rtl/idx_seq.sv
// Index-register instruction sequencer for MU0. Takes one indexed-class
// instruction from the main controller, steps the external index datapath
// through EXEC / MEM / WB (/ INC) and signals completion with done.
// Optional feature macro: IDX_AUTOINC_EN (LDAX/STAX post-increment IDX).
module idx_seq
  import idx_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] opcode,
  input  logic       idx_zero,
  input  logic       mem_ack,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       idxce,
  output logic       acce,
  output logic [1:0] alu_fs,
  output logic       alu_asel,
  output logic       alu_bsel,
  output logic       addr_sel,
  output logic       dsel,
  output logic       mem_req,
  output logic       mem_we,
  output logic       pc_load
);

  // The datapath lives outside; AW only has to be wide enough to be useful.
  if (AW < 4) begin : g_aw_chk
    $error("idx_seq: AW must be at least 4");
  end

  state_t     state_q, state_d;
  logic [3:0] op_q, op_d;

  // State and latched opcode; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 4'h0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic: opcode decides the path, MEM waits on mem_ack.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d = opcode;
          case (opcode)
            OP_LDX, OP_STX, OP_LDAX, OP_STAX: state_d = S_MEM;
            OP_ADX, OP_INX, OP_DEX, OP_JXZ:   state_d = S_EXEC;
            default:                          state_d = S_DONE;
          endcase
        end
      end
      S_EXEC: state_d = S_DONE;
      S_MEM: begin
        if (mem_ack) begin
          case (op_q)
            OP_LDX, OP_LDAX: state_d = S_WB;
`ifdef IDX_AUTOINC_EN
            OP_STAX:         state_d = S_INC;
`endif
            default:         state_d = S_DONE;
          endcase
        end
      end
      S_WB: begin
`ifdef IDX_AUTOINC_EN
        if (op_q == OP_LDAX) state_d = S_INC;
        else                 state_d = S_DONE;
`else
        state_d = S_DONE;
`endif
      end
`ifdef IDX_AUTOINC_EN
      S_INC:  state_d = S_DONE;
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from state and latched opcode (pc_load also sees idx_zero).
  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = 1'b0;
    err      = 1'b0;
    idxce    = 1'b0;
    acce     = 1'b0;
    alu_fs   = FS_PASS_B;
    alu_asel = 1'b0;
    alu_bsel = 1'b0;
    addr_sel = 1'b0;
    dsel     = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    pc_load  = 1'b0;
    case (state_q)
      S_EXEC: begin
        case (op_q)
          OP_ADX: begin
            alu_fs   = FS_ADD;
            alu_asel = 1'b1;
            alu_bsel = 1'b1;
            idxce    = 1'b1;
          end
          OP_INX: begin
            alu_fs   = FS_INC;
            alu_asel = 1'b1;
            idxce    = 1'b1;
          end
          OP_DEX: begin
            alu_fs   = FS_DEC;
            alu_asel = 1'b1;
            idxce    = 1'b1;
          end
          OP_JXZ:  pc_load = idx_zero;
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        case (op_q)
          OP_LDX: addr_sel = 1'b0;
          OP_STX: begin
            mem_we   = 1'b1;
            addr_sel = 1'b0;
            dsel     = 1'b1;
          end
          OP_LDAX: begin
            // Effective address IR + IDX is formed by the ALU.
            alu_fs   = FS_ADD;
            alu_asel = 1'b1;
            alu_bsel = 1'b1;
            addr_sel = 1'b1;
          end
          OP_STAX: begin
            alu_fs   = FS_ADD;
            alu_asel = 1'b1;
            alu_bsel = 1'b1;
            addr_sel = 1'b1;
            mem_we   = 1'b1;
            dsel     = 1'b0;
          end
          default: ;
        endcase
      end
      S_WB: begin
        alu_fs   = FS_PASS_B;
        alu_bsel = 1'b0;
        if (op_q == OP_LDAX) acce  = 1'b1;
        else                 idxce = 1'b1;
      end
`ifdef IDX_AUTOINC_EN
      S_INC: begin
        // Runs after the access, so the address used the old IDX.
        alu_fs   = FS_INC;
        alu_asel = 1'b1;
        idxce    = 1'b1;
      end
`endif
      S_DONE: begin
        done = 1'b1;
        err  = !op_legal(op_q);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_idx_seq.sv
// Directed bench for idx_seq with a small model of the external index
// datapath (IDX/ACC registers, ALU, address mux, memory).
module tb_idx_seq;
  import idx_pkg::*;

`ifdef IDX_AUTOINC_EN
  localparam int AINC = 1;
`else
  localparam int AINC = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, start, idx_zero, mem_ack;
  logic [3:0] opcode;
  logic       busy, done, err, idxce, acce, alu_asel, alu_bsel;
  logic       addr_sel, dsel, mem_req, mem_we, pc_load;
  logic [1:0] alu_fs;
  logic [13:0] outs;

  always #5 clk = ~clk;

  idx_seq #(.AW(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .idx_zero(idx_zero), .mem_ack(mem_ack), .busy(busy), .done(done),
    .err(err), .idxce(idxce), .acce(acce), .alu_fs(alu_fs),
    .alu_asel(alu_asel), .alu_bsel(alu_bsel), .addr_sel(addr_sel),
    .dsel(dsel), .mem_req(mem_req), .mem_we(mem_we), .pc_load(pc_load)
  );

  assign outs = {busy, done, err, idxce, acce, alu_fs, alu_asel, alu_bsel,
                 addr_sel, dsel, mem_req, mem_we, pc_load};

  // External datapath model
  logic [11:0] idx, acc, ir, mdr, alu_a, alu_b, alu_y, addr, wdata;
  logic [11:0] mem [0:4095];
  logic        pre_en;
  logic [11:0] pre_idx, pre_acc;
  logic [11:0] st_addr, st_data;
  int          st_cnt = 0;

  always_comb begin
    alu_a = alu_asel ? idx : acc;
    alu_b = alu_bsel ? ir : mdr;
    case (alu_fs)
      2'd0:    alu_y = alu_b;
      2'd1:    alu_y = alu_a + alu_b;
      2'd2:    alu_y = alu_a + 12'd1;
      default: alu_y = alu_a - 12'd1;
    endcase
    addr  = addr_sel ? alu_y : ir;
    wdata = dsel ? idx : acc;
  end

  assign idx_zero = (idx == 12'h000);

  always @(negedge clk) begin
    if (pre_en) begin
      idx <= pre_idx;
      acc <= pre_acc;
    end else begin
      if (idxce) idx <= alu_y;
      if (acce)  acc <= alu_y;
    end
  end

  always @(posedge clk) begin
    if (mem_req && mem_ack) begin
      if (mem_we) begin
        st_addr <= addr;
        st_data <= wdata;
        st_cnt  <= st_cnt + 1;
      end else begin
        mdr <= mem[addr];
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [11:0] i, input logic [11:0] a);
    pre_idx = i;
    pre_acc = a;
    pre_en  = 1'b1;
    @(negedge clk);
    #1;
    pre_en  = 1'b0;
  endtask

  int          done_cyc, n_done, n_idxce, n_acce, n_req, n_we, n_pc, n_err, addr_var;
  logic [1:0]  fs_seen;
  logic [11:0] req_addr;

  // Issue one instruction; cycle 1 is the first cycle after acceptance.
  // inj > 0 pulses an INX start in that cycle while the block is busy.
  task automatic run_op(input logic [3:0] op, input int waits, input int inj);
    int m;
    int c;
    m = 0; c = 0;
    done_cyc = -1; n_done = 0; n_idxce = 0; n_acce = 0; n_req = 0;
    n_we = 0; n_pc = 0; n_err = 0; addr_var = 0; fs_seen = 2'd0; req_addr = 12'h0;
    @(posedge clk); #1;
    opcode = op;
    start  = 1'b1;
    while (c < 60 && (done_cyc < 0 || c < done_cyc + 3)) begin
      @(posedge clk); #1;
      c++;
      if (c == inj) begin
        start  = 1'b1;
        opcode = OP_INX;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (err) n_err++;
      if (idxce) begin
        n_idxce++;
        fs_seen = alu_fs;
      end
      if (acce) n_acce++;
      if (pc_load) n_pc++;
      if (mem_req) begin
        if (m == 0) req_addr = addr;
        else if (addr != req_addr) addr_var++;
        m++;
        n_req++;
        if (mem_we) n_we++;
        mem_ack = (m > waits);
      end else begin
        mem_ack = 1'b0;
      end
    end
    mem_ack = 1'b0;
    start   = 1'b0;
  endtask

  initial begin
    int nd, first_d, last_d, stc;
    rst_n = 1'b0; start = 1'b0; opcode = 4'h0; mem_ack = 1'b0; pre_en = 1'b0;
    ir = 12'h000; pre_idx = 12'h0; pre_acc = 12'h0; mdr = 12'h0;
    for (int i = 0; i < 4096; i++) mem[i] = 12'h000;
    mem[12'h020] = 12'h123;
    mem[12'h015] = 12'h0AB;

    @(posedge clk); #1;
    check("reset_outputs", 32'(outs), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // INX wraps 0xFFF -> 0x000
    preload(12'hFFF, 12'h000);
    run_op(OP_INX, 0, 0);
    check("inx_done_cyc", done_cyc, 2);
    check("inx_idxce_cnt", n_idxce, 1);
    check("inx_fs", 32'(fs_seen), 32'(FS_INC));
    check("inx_err", n_err, 0);
    check("inx_idx", 32'(idx), 32'h000);

    // DEX wraps 0x000 -> 0xFFF
    run_op(OP_DEX, 0, 0);
    check("dex_fs", 32'(fs_seen), 32'(FS_DEC));
    check("dex_idx", 32'(idx), 32'hFFF);

    // ADX: IDX + IR
    preload(12'h005, 12'h000);
    ir = 12'h00A;
    run_op(OP_ADX, 0, 0);
    check("adx_done_cyc", done_cyc, 2);
    check("adx_idx", 32'(idx), 32'h00F);

    // LDX from 0x020, no wait
    ir = 12'h020;
    run_op(OP_LDX, 0, 0);
    check("ldx_done_cyc", done_cyc, 3);
    check("ldx_req_cnt", n_req, 1);
    check("ldx_addr", 32'(req_addr), 32'h020);
    check("ldx_we_cnt", n_we, 0);
    check("ldx_idx", 32'(idx), 32'h123);

    // LDAX IR=0x010 IDX=0x005, three wait cycles
    preload(12'h005, 12'h000);
    ir = 12'h010;
    run_op(OP_LDAX, 3, 0);
    check("ldax_req_cnt", n_req, 4);
    check("ldax_addr", 32'(req_addr), 32'h015);
    check("ldax_addr_stable", addr_var, 0);
    check("ldax_acce_cnt", n_acce, 1);
    check("ldax_acc", 32'(acc), 32'h0AB);
    check("ldax_done_cyc", done_cyc, 6 + AINC);
    check("ldax_idx", 32'(idx), 32'(12'h005 + 12'(AINC)));

    // STAX with wrapping effective address 0x100 + 0xFFF = 0x0FF
    preload(12'hFFF, 12'h0AB);
    ir = 12'h100;
    stc = st_cnt;
    run_op(OP_STAX, 0, 0);
    check("stax_done_cyc", done_cyc, 2 + AINC);
    check("stax_we_cnt", n_we, 1);
    check("stax_st_addr", 32'(st_addr), 32'h0FF);
    check("stax_st_data", 32'(st_data), 32'h0AB);
    check("stax_st_cnt", st_cnt - stc, 1);
    check("stax_idx", 32'(idx), 32'(12'hFFF + 12'(AINC)));

    // JXZ taken and not taken
    preload(12'h000, 12'h000);
    run_op(OP_JXZ, 0, 0);
    check("jxz_z_pc_cnt", n_pc, 1);
    check("jxz_z_done_cyc", done_cyc, 2);
    preload(12'h007, 12'h000);
    run_op(OP_JXZ, 0, 0);
    check("jxz_nz_pc_cnt", n_pc, 0);
    check("jxz_nz_done_cyc", done_cyc, 2);

    // Illegal opcode
    run_op(4'h3, 0, 0);
    check("ill_done_cyc", done_cyc, 1);
    check("ill_err_cnt", n_err, 1);
    check("ill_enables", n_idxce + n_acce + n_req, 0);

    // STX with a start pulse while busy
    preload(12'h456, 12'h000);
    ir = 12'h030;
    stc = st_cnt;
    run_op(OP_STX, 5, 2);
    check("stx_done_cyc", done_cyc, 7);
    check("stx_done_cnt", n_done, 1);
    check("stx_idxce_cnt", n_idxce, 0);
    check("stx_st_addr", 32'(st_addr), 32'h030);
    check("stx_st_data", 32'(st_data), 32'h456);
    check("stx_idx", 32'(idx), 32'h456);
    check("stx_idle", 32'(busy), 32'h0);

    // Back-to-back INX with start held high
    preload(12'h010, 12'h000);
    @(posedge clk); #1;
    opcode = OP_INX;
    start  = 1'b1;
    nd = 0; first_d = -1; last_d = -1;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      if (c == 8) start = 1'b0;
      if (done) begin
        nd++;
        if (first_d < 0) first_d = c;
        last_d = c;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    check("b2b_done_cnt", nd, 3);
    check("b2b_first", first_d, 2);
    check("b2b_last", last_d, 8);
    check("b2b_idx", 32'(idx), 32'h013);

    // Reset in the middle of LDX MEM
    ir = 12'h020;
    preload(12'h055, 12'h000);
    @(posedge clk); #1;
    opcode = OP_LDX;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("rst_ldx_in_mem", 32'(mem_req), 32'h1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", 32'(outs), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (outs != 14'h0) nd++;
    end
    check("rst_no_activity", nd, 0);
    check("rst_idx_kept", 32'(idx), 32'h055);

    // Normal operation after the abort
    run_op(OP_INX, 0, 0);
    check("post_rst_done_cyc", done_cyc, 2);
    check("post_rst_idx", 32'(idx), 32'h056);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
